radial_zone_table_loader: RTL and testbench
===========================================

Name: radial_zone_table_loader

Overview:
- Programs the per-zone coefficient tables (r_squared, a, b) that feed the radial a/b zone selector in the dfdd pipeline.
- Accepts a ready/valid configuration word stream into a shadow bank and validates framing and radius ordering.
- Commits the shadow bank to the active outputs only on a frame boundary, so the selector never sees a half-written table mid-frame.

Parameters:
- NO_ZONES, 1, number of radial zones; must be >= 1.

Ports:
- clk_i  input  1  clock
- rst_n_i  input  1  synchronous active-low reset
- cfg_valid_i  input  1  configuration word valid
- cfg_ready_o  output  1  loader can accept a word
- cfg_data_i  input  18  word payload; a/b words use [15:0], [17:16] ignored
- cfg_last_i  input  1  marks final word of a table
- frame_start_i  input  1  one-cycle pulse at the first pixel of a frame
- a_o  output  16 x NO_ZONES  active fp16 a coefficients
- b_o  output  16 x NO_ZONES  active fp16 b coefficients
- r_squared_o  output  18 x NO_ZONES  active squared zone radii
- table_valid_o  output  1  high once any table has been committed
- commit_o  output  1  one-cycle pulse: active bank changed this cycle
- err_o  output  1  one-cycle pulse: table rejected
- err_code_o  output  2  1 = framing error, 2 = radius order error; held until the next error

Behaviour:
- Reset: the following clear to 0 on the first rising edge with rst_n_i=0, and stay 0 while it is held low:
  - a_o, b_o, r_squared_o, shadow bank, word index
  - table_valid_o, commit_o, err_o, err_code_o
- Reset mid-load or while PENDING discards everything, including the active bank. The state is LOAD after reset.
- Word order: for z = 0..NO_ZONES-1 the words are r_squared[z], a[z], b[z]. That is 3*NO_ZONES words; index idx counts 0..3*NO_ZONES-1 with width clog2(3*NO_ZONES) (minimum 1).
- Transfer: a word is accepted when cfg_valid_i && cfg_ready_o at the rising edge. cfg_ready_o = (state==LOAD) and is purely state-derived, with no combinational path from cfg_valid_i.
- States:
  - LOAD: accept words into the shadow bank.
  - PENDING: shadow complete and validated, waiting for a frame boundary; cfg_ready_o=0.
- LOAD -> PENDING: the accepted word has idx==3*NO_ZONES-1, cfg_last_i=1, and no order violation was recorded.
- Framing error (code 1): either
  - cfg_last_i=1 on an accepted word with idx != 3*NO_ZONES-1, or
  - cfg_last_i=0 on the word with idx==3*NO_ZONES-1.
  - Response: err_o pulses the next cycle, idx resets to 0, the shadow contents are invalid, the state stays LOAD, and the active bank is untouched.
- Order check: on acceptance of r_squared[z] with z>0, an order violation is recorded if the value <= shadow r_squared[z-1] (unsigned).
  - The check is evaluated when the table completes.
  - If set at the final word: err_code_o=2, err_o pulses, idx=0, state LOAD, and the flag clears.
- Commit: in PENDING, when frame_start_i=1 at the edge:
  - the active bank is loaded from shadow;
  - the new values, table_valid_o=1 and commit_o=1 are all visible in the cycle after the edge;
  - the state returns to LOAD with idx=0.
- Simultaneous events:
  - frame_start_i in the same cycle as the completing word does not commit; the commit happens at the next frame_start_i.
  - frame_start_i in LOAD is ignored.
  - Repeated frame_start_i in PENDING commits once.
- Active outputs change only at commit or reset. Shadow writes never alter a_o/b_o/r_squared_o.
- NO_ZONES=1: the table is 3 words and the order check is never active.

Test Plan:
- NO_ZONES=2, load r2 {100, 400}, a {0x3C00, 0x4000}, b {0x3800, 0x3400} with last on word 5; then pulse frame_start_i -> after the load, cfg_ready_o=0 and outputs stay 0. After frame_start_i: commit_o=1 for one cycle, r_squared_o={100,400}, a_o={0x3C00,0x4000}, b_o={0x3800,0x3400}, table_valid_o=1.
- Random cfg_valid_i gaps, then completion in the same cycle as frame_start_i -> no commit that cycle; commit on the following frame_start_i pulse 50 cycles later.
- cfg_last_i on word 3 -> err_o pulse, err_code_o=1, previous active bank unchanged; a subsequent correct 6-word load is accepted and commits.
- r2 {400, 400} -> err_code_o=2 after word 5, no transition to PENDING, active bank unchanged.
- A second valid table loaded mid-frame while table 1 is active -> a_o/b_o/r_squared_o hold the table-1 values until the next frame_start_i, then switch in one cycle.
- Assert rst_n_i low during PENDING for 2 cycles -> all outputs 0, table_valid_o=0, cfg_ready_o=1 after release, and a subsequent frame_start_i causes no commit.

Source files
------------

// File: rtl/radial_zone_table_loader_if.sv
// Configuration word stream for the radial zone table loader.
// The producer (master) drives valid/data/last; the loader (slave) returns ready.
interface radial_zone_table_loader_if;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic [17:0] cfg_data_i;
  logic        cfg_last_i;

  modport master (
    output cfg_valid_i,
    output cfg_data_i,
    output cfg_last_i,
    input  cfg_ready_o
  );

  modport slave (
    input  cfg_valid_i,
    input  cfg_data_i,
    input  cfg_last_i,
    output cfg_ready_o
  );
endinterface

// File: rtl/radial_zone_table_loader.sv
// Radial zone table loader: collects r_squared/a/b words per zone into a shadow
// bank, validates framing and strictly increasing radii, and copies the shadow
// bank to the active outputs only on a frame_start_i pulse.
module radial_zone_table_loader #(
  parameter int NO_ZONES = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  radial_zone_table_loader_if.slave      cfg_if,
  input  logic                           frame_start_i,
  output logic [NO_ZONES-1:0][15:0]      a_o,
  output logic [NO_ZONES-1:0][15:0]      b_o,
  output logic [NO_ZONES-1:0][17:0]      r_squared_o,
  output logic                           table_valid_o,
  output logic                           commit_o,
  output logic                           err_o,
  output logic [1:0]                     err_code_o
);

  localparam int NW = 3 * NO_ZONES;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int ZW = (NO_ZONES > 1) ? $clog2(NO_ZONES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

  typedef enum logic {
    ST_LOAD    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [ZW-1:0]               zone_q, zone_d;
  logic [1:0]                  sel_q, sel_d;
  logic                        ord_err_q, ord_err_d;
  logic [NO_ZONES-1:0][17:0]   sh_r2_q, sh_r2_d;
  logic [NO_ZONES-1:0][15:0]   sh_a_q, sh_a_d;
  logic [NO_ZONES-1:0][15:0]   sh_b_q, sh_b_d;
  logic [NO_ZONES-1:0][17:0]   act_r2_q, act_r2_d;
  logic [NO_ZONES-1:0][15:0]   act_a_q, act_a_d;
  logic [NO_ZONES-1:0][15:0]   act_b_q, act_b_d;
  logic                        table_valid_q, table_valid_d;
  logic                        commit_q, commit_d;
  logic                        err_q, err_d;
  logic [1:0]                  err_code_q, err_code_d;

  logic                        accept_s;
  logic                        is_final_s;
  logic [17:0]                 prev_r2_s;
  logic                        viol_s;

  // Ready depends only on state, never on cfg_valid_i.
  assign cfg_if.cfg_ready_o = (state_q == ST_LOAD);

  assign r_squared_o   = act_r2_q;
  assign a_o           = act_a_q;
  assign b_o           = act_b_q;
  assign table_valid_o = table_valid_q;
  assign commit_o      = commit_q;
  assign err_o         = err_q;
  assign err_code_o    = err_code_q;

  // Word acceptance, radius order check and next-state/output computation.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    zone_d        = zone_q;
    sel_d         = sel_q;
    ord_err_d     = ord_err_q;
    sh_r2_d       = sh_r2_q;
    sh_a_d        = sh_a_q;
    sh_b_d        = sh_b_q;
    act_r2_d      = act_r2_q;
    act_a_d       = act_a_q;
    act_b_d       = act_b_q;
    table_valid_d = table_valid_q;
    commit_d      = 1'b0;
    err_d         = 1'b0;
    err_code_d    = err_code_q;

    accept_s   = cfg_if.cfg_valid_i && (state_q == ST_LOAD);
    is_final_s = (idx_q == LAST_IDX);

    // Radius of the previous zone; zone 0 has no predecessor.
    prev_r2_s = 18'd0;
    for (int z = 1; z < NO_ZONES; z++) begin
      if (zone_q == ZW'(z)) begin
        prev_r2_s = sh_r2_q[z-1];
      end else begin
        prev_r2_s = prev_r2_s;
      end
    end
    viol_s = (sel_q == 2'd0) && (zone_q != {ZW{1'b0}}) &&
             (cfg_if.cfg_data_i <= prev_r2_s);

    case (state_q)
      ST_LOAD: begin
        if (accept_s) begin
          // Store the word in its shadow slot; a bad table is simply discarded later.
          for (int z = 0; z < NO_ZONES; z++) begin
            if (zone_q == ZW'(z)) begin
              case (sel_q)
                2'd0:    sh_r2_d[z] = cfg_if.cfg_data_i;
                2'd1:    sh_a_d[z]  = cfg_if.cfg_data_i[15:0];
                2'd2:    sh_b_d[z]  = cfg_if.cfg_data_i[15:0];
                default: sh_r2_d[z] = sh_r2_q[z];
              endcase
            end else begin
              sh_r2_d[z] = sh_r2_d[z];
            end
          end

          if (cfg_if.cfg_last_i != is_final_s) begin
            // Framing error: last flag missing or early.
            err_d      = 1'b1;
            err_code_d = 2'd1;
            idx_d      = {IW{1'b0}};
            zone_d     = {ZW{1'b0}};
            sel_d      = 2'd0;
            ord_err_d  = 1'b0;
          end else if (is_final_s) begin
            idx_d     = {IW{1'b0}};
            zone_d    = {ZW{1'b0}};
            sel_d     = 2'd0;
            ord_err_d = 1'b0;
            if (ord_err_q) begin
              err_d      = 1'b1;
              err_code_d = 2'd2;
            end else begin
              state_d = ST_PENDING;
            end
          end else begin
            idx_d     = idx_q + IW'(1);
            ord_err_d = ord_err_q | viol_s;
            if (sel_q == 2'd2) begin
              sel_d  = 2'd0;
              zone_d = zone_q + ZW'(1);
            end else begin
              sel_d  = sel_q + 2'd1;
            end
          end
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_PENDING: begin
        if (frame_start_i) begin
          act_r2_d      = sh_r2_q;
          act_a_d       = sh_a_q;
          act_b_d       = sh_b_q;
          table_valid_d = 1'b1;
          commit_d      = 1'b1;
          state_d       = ST_LOAD;
          idx_d         = {IW{1'b0}};
          zone_d        = {ZW{1'b0}};
          sel_d         = 2'd0;
          ord_err_d     = 1'b0;
        end else begin
          state_d = ST_PENDING;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State, shadow and active bank registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_LOAD;
      idx_q         <= {IW{1'b0}};
      zone_q        <= {ZW{1'b0}};
      sel_q         <= 2'd0;
      ord_err_q     <= 1'b0;
      sh_r2_q       <= '0;
      sh_a_q        <= '0;
      sh_b_q        <= '0;
      act_r2_q      <= '0;
      act_a_q       <= '0;
      act_b_q       <= '0;
      table_valid_q <= 1'b0;
      commit_q      <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      zone_q        <= zone_d;
      sel_q         <= sel_d;
      ord_err_q     <= ord_err_d;
      sh_r2_q       <= sh_r2_d;
      sh_a_q        <= sh_a_d;
      sh_b_q        <= sh_b_d;
      act_r2_q      <= act_r2_d;
      act_a_q       <= act_a_d;
      act_b_q       <= act_b_d;
      table_valid_q <= table_valid_d;
      commit_q      <= commit_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

endmodule

// File: tb/tb_radial_zone_table_loader.sv
// Directed bench for radial_zone_table_loader with two zones.
module tb_radial_zone_table_loader;

  localparam int NZ = 2;

  logic                    clk;
  logic                    rst_n;
  logic                    frame_start;
  logic [NZ-1:0][15:0]     a_o;
  logic [NZ-1:0][15:0]     b_o;
  logic [NZ-1:0][17:0]     r2_o;
  logic                    table_valid;
  logic                    commit;
  logic                    err;
  logic [1:0]              err_code;

  int n_cmp = 0;
  int n_err = 0;

  radial_zone_table_loader_if cfg_if ();

  radial_zone_table_loader #(.NO_ZONES(NZ)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .cfg_if        (cfg_if.slave),
    .frame_start_i (frame_start),
    .a_o           (a_o),
    .b_o           (b_o),
    .r_squared_o   (r2_o),
    .table_valid_o (table_valid),
    .commit_o      (commit),
    .err_o         (err),
    .err_code_o    (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bank(input string tag, input logic [17:0] r0, input logic [17:0] r1,
                          input logic [15:0] a0, input logic [15:0] a1,
                          input logic [15:0] b0, input logic [15:0] b1);
    logic [NZ-1:0][17:0] er;
    logic [NZ-1:0][15:0] ea;
    logic [NZ-1:0][15:0] eb;
    er = {r1, r0};
    ea = {a1, a0};
    eb = {b1, b0};
    chk({tag, ".r2"}, 64'(r2_o), 64'(er));
    chk({tag, ".a"},  64'(a_o),  64'(ea));
    chk({tag, ".b"},  64'(b_o),  64'(eb));
  endtask

  // Sends words 0..n-1 of w; cfg_last on last_pos; optional idle gaps and a
  // frame_start pulse coincident with the final word sent.
  task automatic send_words(input logic [5:0][17:0] w, input int n, input int last_pos,
                            input bit gaps, input bit fs_final);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) tick();
      end
      cfg_if.cfg_valid_i = 1'b1;
      cfg_if.cfg_data_i  = w[i];
      cfg_if.cfg_last_i  = (i == last_pos);
      frame_start        = fs_final && (i == n - 1);
      tick();
      cfg_if.cfg_valid_i = 1'b0;
      cfg_if.cfg_last_i  = 1'b0;
      cfg_if.cfg_data_i  = 18'h3FFFF;
      frame_start        = 1'b0;
    end
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    logic [5:0][17:0] t_a, t_b, t_c, t_bad, t_d;
    int commits_seen;

    // word order per zone: r2, a, b
    t_a   = {18'h03400, 18'h04000, 18'd400,  18'h03800, 18'h03C00, 18'd100};
    t_b   = {18'h02C00, 18'h04400, 18'd900,  18'h03000, 18'h04200, 18'd200};
    t_c   = {18'h04444, 18'h02222, 18'd60,   18'h03333, 18'h01111, 18'd50};
    t_bad = {18'h0AAAA, 18'h0BBBB, 18'd400,  18'h0CCCC, 18'h0DDDD, 18'd400};
    t_d   = {18'h00123, 18'h06666, 18'd2000, 18'h07777, 18'h05555, 18'd1000};

    rst_n              = 1'b0;
    frame_start        = 1'b0;
    cfg_if.cfg_valid_i = 1'b0;
    cfg_if.cfg_data_i  = 18'd0;
    cfg_if.cfg_last_i  = 1'b0;

    // reset state
    tick();
    tick();
    chk_bank("rst", 18'd0, 18'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    chk("rst.tv", 64'(table_valid), 64'd0);
    chk("rst.commit", 64'(commit), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    chk("rst.code", 64'(err_code), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst.ready", 64'(cfg_if.cfg_ready_o), 64'd1);

    // basic load then commit
    send_words(t_a, 6, 5, 1'b0, 1'b0);
    chk("ldA.ready", 64'(cfg_if.cfg_ready_o), 64'd0);
    chk("ldA.commit", 64'(commit), 64'd0);
    chk("ldA.tv", 64'(table_valid), 64'd0);
    chk_bank("ldA.pre", 18'd0, 18'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    tick();
    pulse_fs();
    chk("cmA.commit", 64'(commit), 64'd1);
    chk("cmA.tv", 64'(table_valid), 64'd1);
    chk_bank("cmA", 18'd100, 18'd400, 16'h3C00, 16'h4000, 16'h3800, 16'h3400);
    chk("cmA.ready", 64'(cfg_if.cfg_ready_o), 64'd1);
    tick();
    chk("cmA.pulse", 64'(commit), 64'd0);

    // gapped load completing together with frame_start: no commit yet
    send_words(t_b, 6, 5, 1'b1, 1'b1);
    chk("ldB.commit", 64'(commit), 64'd0);
    chk("ldB.ready", 64'(cfg_if.cfg_ready_o), 64'd0);
    commits_seen = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (commit) commits_seen++;
    end
    chk("ldB.idle_commits", 64'(commits_seen), 64'd0);
    chk_bank("ldB.hold", 18'd100, 18'd400, 16'h3C00, 16'h4000, 16'h3800, 16'h3400);
    pulse_fs();
    chk("cmB.commit", 64'(commit), 64'd1);
    chk_bank("cmB", 18'd200, 18'd900, 16'h4200, 16'h4400, 16'h3000, 16'h2C00);

    // framing error: last on word 3
    send_words(t_c, 4, 3, 1'b0, 1'b0);
    chk("frm.err", 64'(err), 64'd1);
    chk("frm.code", 64'(err_code), 64'd1);
    chk("frm.ready", 64'(cfg_if.cfg_ready_o), 64'd1);
    tick();
    chk("frm.pulse", 64'(err), 64'd0);
    chk("frm.code_hold", 64'(err_code), 64'd1);
    chk_bank("frm.bank", 18'd200, 18'd900, 16'h4200, 16'h4400, 16'h3000, 16'h2C00);
    send_words(t_c, 6, 5, 1'b0, 1'b0);
    chk("ldC.ready", 64'(cfg_if.cfg_ready_o), 64'd0);
    pulse_fs();
    chk("cmC.commit", 64'(commit), 64'd1);
    chk_bank("cmC", 18'd50, 18'd60, 16'h1111, 16'h2222, 16'h3333, 16'h4444);

    // radius order error: {400, 400}
    send_words(t_bad, 6, 5, 1'b0, 1'b0);
    chk("ord.err", 64'(err), 64'd1);
    chk("ord.code", 64'(err_code), 64'd2);
    chk("ord.ready", 64'(cfg_if.cfg_ready_o), 64'd1);
    pulse_fs();
    chk("ord.commit", 64'(commit), 64'd0);
    chk_bank("ord.bank", 18'd50, 18'd60, 16'h1111, 16'h2222, 16'h3333, 16'h4444);

    // mid-frame load holds old table; two-cycle frame_start commits once
    send_words(t_d, 6, 5, 1'b1, 1'b0);
    chk_bank("ldD.hold", 18'd50, 18'd60, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    frame_start = 1'b1;
    tick();
    chk("cmD.commit", 64'(commit), 64'd1);
    chk_bank("cmD", 18'd1000, 18'd2000, 16'h5555, 16'h6666, 16'h7777, 16'h0123);
    tick();
    frame_start = 1'b0;
    chk("cmD.once", 64'(commit), 64'd0);

    // reset while PENDING discards everything
    send_words(t_a, 6, 5, 1'b0, 1'b0);
    chk("ldE.ready", 64'(cfg_if.cfg_ready_o), 64'd0);
    rst_n = 1'b0;
    tick();
    chk_bank("rst2.a", 18'd0, 18'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    chk("rst2.tv", 64'(table_valid), 64'd0);
    tick();
    chk("rst2.code", 64'(err_code), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst2.ready", 64'(cfg_if.cfg_ready_o), 64'd1);
    pulse_fs();
    chk("rst2.commit", 64'(commit), 64'd0);
    chk("rst2.tv_after", 64'(table_valid), 64'd0);
    chk_bank("rst2.b", 18'd0, 18'd0, 16'd0, 16'd0, 16'd0, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
